// File: rtl/bram_port_pkg.sv
// Shared constants for the block-RAM port master and its response FIFO.
package bram_port_pkg;

  // Default RAM geometry.
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  // Smallest response FIFO that still sustains one request per cycle.
  localparam int RESP_DEPTH_MIN = 3;

  // Request opcode carried on REQ_WE.
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_port_master_if.sv
// Request, response and RAM-pin bundle of the block-RAM port master.
// slave  : the port master itself (serves requests, drives the RAM pins).
// master : the client side plus the RAM primitive (issues requests, returns DO).
interface bram_port_master_if
  import bram_port_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          REQ_VALID;
  logic          REQ_READY;
  logic          REQ_WE;
  logic [AW-1:0] REQ_ADDR;
  logic [DW-1:0] REQ_WDATA;

  logic          RSP_VALID;
  logic          RSP_READY;
  logic [DW-1:0] RSP_RDATA;

  logic          RAM_EN;
  logic          RAM_WE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DI;
  logic [DW-1:0] RAM_DO;

  logic          BUSY;

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY, RAM_DO,
    output REQ_READY, RSP_VALID, RSP_RDATA, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, BUSY
  );

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, RSP_READY, RAM_DO,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RAM_EN, RAM_WE, RAM_ADDR, RAM_DI, BUSY
  );

endinterface

// File: rtl/bram_rsp_fifo.sv
// Small synchronous FIFO buffering captured read data until the consumer takes it.
// Overflow/underflow protection is left to the caller's credit logic.
module bram_rsp_fifo
  import bram_port_pkg::*;
#(
  parameter  int DW         = DW_DEF,
  parameter  int RESP_DEPTH = RESP_DEPTH_MIN,
  localparam int CNT_W      = cnt_width(RESP_DEPTH)
) (
  input  logic             CLKA,
  input  logic             RSTB,
  input  logic             push_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  output logic [DW-1:0]    head_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);

  logic [DW-1:0]    mem_q [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap at RESP_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Next-state for pointers and occupancy.
  // NOTE: every variable gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous active-high reset.
  // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage write port.
  // NOTE: storage is deliberately not reset; count_q decides which entries are meaningful.
  always_ff @(posedge CLKA) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/bram_port_master.sv
// Turns a valid/ready read/write request stream into single-cycle-latency block
// RAM port cycles and returns read data in issue order through a credit-managed
// response FIFO.
module bram_port_master
  import bram_port_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_MIN
) (
  input logic CLKA,
  input logic RSTB,
  bram_port_master_if.slave bus
);

  localparam int CNT_W = cnt_width(RESP_DEPTH);
  // One extra bit so count + rd_pend cannot overflow before the compare.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(RESP_DEPTH);

  logic             rd_pend_q, rd_pend_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    di_q, di_d;
  logic [CNT_W-1:0] fifo_count;
  logic [DW-1:0]    fifo_head;
  logic [CNT_W:0]   credit_used;
  logic             req_ready;
  logic             acc;
  logic             rsp_valid;
  logic             rsp_pop;

  // Credit: a read may only be accepted if its response has a guaranteed FIFO
  // slot. Only registered state feeds this, so REQ_READY never combinationally
  // depends on REQ_VALID or RSP_READY; writes are throttled the same way.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
    req_ready   = !RSTB && (credit_used < DEPTH_C);
  end

  // Accept decode and RAM address/data next-state; pins hold the last accepted
  // request when idle to avoid needless toggling.
  always_comb begin
    acc       = bus.REQ_VALID && req_ready;
    addr_d    = addr_q;
    di_d      = di_q;
    rd_pend_d = acc && (bus.REQ_WE == OP_RD);
    if (acc) begin
      addr_d = bus.REQ_ADDR;
      di_d   = bus.REQ_WDATA;
    end
  end

  // Read-pending flag and held RAM pin values.
  always_ff @(posedge CLKA) begin
    if (RSTB) begin
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      di_q      <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      addr_q    <= addr_d;
      di_q      <= di_d;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RAM_EN    = acc;
  assign bus.RAM_WE    = acc && (bus.REQ_WE == OP_WR);
  assign bus.RAM_ADDR  = addr_d;
  assign bus.RAM_DI    = di_d;

  // RAM_DO is valid in the cycle after a read was issued; capture it then.
  bram_rsp_fifo #(
    .DW         (DW),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .CLKA        (CLKA),
    .RSTB        (RSTB),
    .push_i      (rd_pend_q),
    .push_data_i (bus.RAM_DO),
    .pop_i       (rsp_pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count)
  );

  // Response side: masked during reset so nothing stale is presented or popped.
  assign rsp_valid     = !RSTB && (fifo_count != '0);
  assign rsp_pop       = rsp_valid && bus.RSP_READY;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_valid ? fifo_head : '0;
  assign bus.BUSY      = rd_pend_q || (fifo_count != '0);

endmodule

// File: tb/tb_bram_port_master.sv
// Self-checking bench for bram_port_master: directed scenarios plus a randomized
// run against a transaction-level reference model (ordered response queue).
module tb_bram_port_master;
  import bram_port_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 3;

  logic          clka = 1'b0;
  logic          rstb = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clka = ~clka;

  bram_port_master_if #(.AW(AW), .DW(DW)) bus ();

  bram_port_master #(.AW(AW), .DW(DW), .RESP_DEPTH(DEPTH)) dut (
    .CLKA (clka),
    .RSTB (rstb),
    .bus  (bus)
  );

  // Block RAM primitive: single-cycle latency, write-first.
  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] ram_do = '0;
  always @(posedge clka) begin
    if (bus.RAM_EN) begin
      if (bus.RAM_WE) begin
        ram[bus.RAM_ADDR] <= bus.RAM_DI;
        ram_do            <= bus.RAM_DI;
      end else begin
        ram_do <= ram[bus.RAM_ADDR];
      end
    end
  end

  assign bus.REQ_VALID = req_valid;
  assign bus.REQ_WE    = req_we;
  assign bus.REQ_ADDR  = req_addr;
  assign bus.REQ_WDATA = req_wdata;
  assign bus.RSP_READY = rsp_ready;
  assign bus.RAM_DO    = ram_do;

  // Reference model: memory contents as seen by the request stream, and the
  // ordered list of owed responses with the cycle each becomes visible.
  typedef struct {
    logic [DW-1:0] data;
    int            vis;
  } rsp_t;

  rsp_t          exp_q [$];
  logic [DW-1:0] mdl_mem [2**AW];
  int            cyc = 0;
  logic          exp_ready, exp_valid, exp_busy, exp_en, exp_we;
  logic [DW-1:0] exp_rdata;

  task automatic set_req(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[a]     = d;
    mdl_mem[a] = d;
  endtask

  // Compute the model's expectations for this cycle, then move to the sample point.
  task automatic settle();
    exp_ready = !rstb && (exp_q.size() < DEPTH);
    exp_valid = !rstb && (exp_q.size() != 0) && (exp_q[0].vis <= cyc);
    exp_rdata = exp_valid ? exp_q[0].data : '0;
    exp_busy  = (exp_q.size() != 0);
    exp_en    = req_valid && exp_ready;
    exp_we    = exp_en && req_we;
    @(negedge clka);
  endtask

  // Cross the active edge and apply this cycle's transactions to the model.
  task automatic advance();
    rsp_t r;
    @(posedge clka);
    if (rstb) begin
      exp_q.delete();
    end else begin
      if (exp_valid && rsp_ready) exp_q.delete(0);
      if (exp_en) begin
        if (req_we) mdl_mem[req_addr] = req_wdata;
        else begin
          r.data = mdl_mem[req_addr];
          r.vis  = cyc + 2;
          exp_q.push_back(r);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    set_req(1'b1, 1'b0, 8'h05, '0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bus.REQ_READY); end
      checks++; if (bus.RAM_EN !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b expected 0", bus.RAM_EN); end
      checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.RSP_VALID); end
      if (i > 0) begin
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.BUSY); end
      end
      advance();
    end
    rstb = 1'b0;
    set_req(1'b0, 1'b0, '0, '0);
    settle();
    checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL release_req_ready: got %b expected 1", bus.REQ_READY); end
    checks++; if (bus.RSP_RDATA !== 16'h0000) begin errors++; $display("FAIL release_rsp_rdata: got %h expected 0000", bus.RSP_RDATA); end
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL release_busy: got %b expected 0", bus.BUSY); end
    advance();
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    set_req(1'b1, OP_WR, 8'h10, 16'hBEEF);
    settle();
    checks++; if (bus.RAM_WE !== 1'b1) begin errors++; $display("FAIL wr_ram_we: got %b expected 1", bus.RAM_WE); end
    checks++; if (bus.RAM_ADDR !== 8'h10) begin errors++; $display("FAIL wr_ram_addr: got %h expected 10", bus.RAM_ADDR); end
    checks++; if (bus.RAM_DI !== 16'hBEEF) begin errors++; $display("FAIL wr_ram_di: got %h expected beef", bus.RAM_DI); end
    advance();
    set_req(1'b1, OP_RD, 8'h10, 16'h0000);
    settle();
    checks++; if (bus.RAM_EN !== 1'b1 || bus.RAM_WE !== 1'b0) begin errors++; $display("FAIL rd_ram_en_we: got en=%b we=%b expected en=1 we=0", bus.RAM_EN, bus.RAM_WE); end
    advance();
    set_req(1'b0, OP_RD, 8'h77, 16'h1234);
    settle();
    checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL wrrd_early_valid: got %b expected 0", bus.RSP_VALID); end
    checks++; if (bus.RAM_EN !== 1'b0 || bus.RAM_WE !== 1'b0) begin errors++; $display("FAIL idle_ram_en_we: got en=%b we=%b expected 0 0", bus.RAM_EN, bus.RAM_WE); end
    checks++; if (bus.RAM_ADDR !== 8'h10) begin errors++; $display("FAIL idle_addr_hold: got %h expected 10", bus.RAM_ADDR); end
    advance();
    settle();
    checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== 16'hBEEF) begin errors++; $display("FAIL wrrd_rsp: got valid=%b data=%h expected valid=1 data=beef", bus.RSP_VALID, bus.RSP_RDATA); end
    advance();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] want;
    for (int k = 0; k < 8; k++) preload(AW'(k), DW'(16'h1000 + k));
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) set_req(1'b1, OP_RD, AW'(i), '0);
      else       set_req(1'b0, OP_RD, '0, '0);
      settle();
      if (i < 8) begin
        checks++; if (bus.REQ_READY !== 1'b1) begin errors++; $display("FAIL stream_ready c%0d: got %b expected 1", i, bus.REQ_READY); end
      end
      if (i >= 2 && i < 10) begin
        want = DW'(16'h1000 + i - 2);
        checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== want) begin errors++; $display("FAIL stream_rsp c%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.RSP_VALID, bus.RSP_RDATA, want); end
      end else begin
        checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL stream_idle c%0d: got valid=%b expected 0", i, bus.RSP_VALID); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] vals [5];
    int idx = 0;
    int nrsp = 0;
    for (int k = 0; k < 5; k++) begin
      vals[k] = DW'($urandom);
      preload(AW'(8'h20 + k), vals[k]);
    end
    for (int c = 0; c < 40 && nrsp < 5; c++) begin
      rsp_ready = (c >= 6);
      set_req(idx < 5, OP_RD, AW'(8'h20 + idx), '0);
      settle();
      if (c == 5) begin
        checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
        checks++; if (bus.REQ_READY !== 1'b0 || bus.RAM_EN !== 1'b0) begin errors++; $display("FAIL bp_stall: got ready=%b en=%b expected 0 0", bus.REQ_READY, bus.RAM_EN); end
      end
      if (c >= 2 && c <= 5) begin
        checks++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_RDATA !== vals[0]) begin errors++; $display("FAIL bp_hold c%0d: got valid=%b data=%h expected valid=1 data=%h", c, bus.RSP_VALID, bus.RSP_RDATA, vals[0]); end
      end
      if (req_valid && bus.REQ_READY) idx++;
      if (bus.RSP_VALID && rsp_ready) begin
        checks++; if (bus.RSP_RDATA !== vals[nrsp]) begin errors++; $display("FAIL bp_order %0d: got %h expected %h", nrsp, bus.RSP_RDATA, vals[nrsp]); end
        nrsp++;
      end
      advance();
    end
    checks++; if (nrsp !== 5) begin errors++; $display("FAIL bp_rsp_count: got %0d expected 5", nrsp); end
    set_req(1'b0, OP_RD, '0, '0);
  endtask

  task automatic test_write_full_credit();
    logic [DW-1:0] vals [3];
    logic [DW-1:0] wval = DW'($urandom);
    logic wr_done = 1'b0;
    int nrsp = 0;
    for (int k = 0; k < 3; k++) begin
      vals[k] = DW'($urandom);
      preload(AW'(8'h40 + k), vals[k]);
    end
    for (int c = 0; c < 20; c++) begin
      rsp_ready = (c >= 5);
      if (c < 3)         set_req(1'b1, OP_RD, AW'(8'h40 + c), '0);
      else if (!wr_done) set_req(1'b1, OP_WR, 8'h30, wval);
      else               set_req(1'b0, OP_RD, '0, '0);
      settle();
      if (c == 3 || c == 4) begin
        checks++; if (bus.REQ_READY !== 1'b0 || bus.RAM_EN !== 1'b0) begin errors++; $display("FAIL full_wr_stall c%0d: got ready=%b en=%b expected 0 0", c, bus.REQ_READY, bus.RAM_EN); end
      end
      if (c == 5) begin
        checks++; if (bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ready: got %b expected 0", bus.REQ_READY); end
      end
      if (c == 6) begin
        checks++; if (bus.REQ_READY !== 1'b1 || bus.RAM_WE !== 1'b1 || bus.RAM_ADDR !== 8'h30) begin errors++; $display("FAIL full_wr_accept: got ready=%b we=%b addr=%h expected 1 1 30", bus.REQ_READY, bus.RAM_WE, bus.RAM_ADDR); end
      end
      if (req_valid && req_we && bus.REQ_READY) wr_done = 1'b1;
      if (bus.RSP_VALID && rsp_ready) begin
        if (nrsp < 3) begin
          checks++; if (bus.RSP_RDATA !== vals[nrsp]) begin errors++; $display("FAIL full_rsp %0d: got %h expected %h", nrsp, bus.RSP_RDATA, vals[nrsp]); end
        end
        nrsp++;
      end
      advance();
    end
    checks++; if (nrsp !== 3) begin errors++; $display("FAIL full_rsp_count: got %0d expected 3", nrsp); end
    checks++; if (ram[8'h30] !== wval) begin errors++; $display("FAIL full_wr_landed: got %h expected %h", ram[8'h30], wval); end
  endtask

  task automatic test_reset_midop();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_req(1'b1, OP_RD, AW'(8'h50 + c), '0);
      settle();
      advance();
    end
    set_req(1'b0, OP_RD, '0, '0);
    rstb = 1'b1;
    settle();
    checks++; if (bus.RSP_VALID !== 1'b0 || bus.REQ_READY !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid=%b ready=%b expected 0 0", bus.RSP_VALID, bus.REQ_READY); end
    advance();
    rstb = 1'b0;
    rsp_ready = 1'b1;
    settle();
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.BUSY); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) settle();
      checks++; if (bus.RSP_VALID !== 1'b0) begin errors++; $display("FAIL midrst_stale c%0d: got valid=%b expected 0", c, bus.RSP_VALID); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rstb      = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      set_req($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      settle();
      checks++; if (bus.REQ_READY !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, bus.REQ_READY, exp_ready); end
      checks++; if (bus.RAM_EN !== exp_en || bus.RAM_WE !== exp_we) begin errors++; $display("FAIL rnd_en_we c%0d: got %b%b expected %b%b", cyc, bus.RAM_EN, bus.RAM_WE, exp_en, exp_we); end
      if (exp_en) begin
        checks++; if (bus.RAM_ADDR !== req_addr || bus.RAM_DI !== req_wdata) begin errors++; $display("FAIL rnd_pins c%0d: got %h/%h expected %h/%h", cyc, bus.RAM_ADDR, bus.RAM_DI, req_addr, req_wdata); end
      end
      checks++; if (bus.RSP_VALID !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, bus.RSP_VALID, exp_valid); end
      if (exp_valid) begin
        checks++; if (bus.RSP_RDATA !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %h expected %h", cyc, bus.RSP_RDATA, exp_rdata); end
      end
      checks++; if (bus.BUSY !== exp_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", cyc, bus.BUSY, exp_busy); end
      advance();
    end
    rstb = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 2**AW; a++) begin
      ram[a]     = '0;
      mdl_mem[a] = '0;
    end
    test_reset();
    test_write_read();
    test_streaming();
    test_backpressure();
    test_write_full_credit();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
